// File: rtl/mux4x1_rr_arbiter_pkg.sv
// Shared definitions for the 4:1 mux round-robin arbiter: FSM encoding,
// requester count and a small one-hot helper.
package mux4x1_ctrl_defs;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4x1_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter; the arbiter
// side (master) drives the grant and the mux selects.
interface mux4x1_rr_arbiter_if;
  import mux4x1_ctrl_defs::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             sel1;
  logic             sel0;
  logic             busy;
  logic             timeout;

  modport master (
    input  req,
    output gnt, sel1, sel0, busy, timeout
  );

  modport slave (
    output req,
    input  gnt, sel1, sel0, busy, timeout
  );

endinterface

// File: rtl/mux4x1_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick: first set request searching from ptr
// upward, modulo four.
module rr_pick4
  import mux4x1_ctrl_defs::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    idx_o   = ptr_i;
    valid_o = |req_i;
    cand    = ptr_i;
    // Walk from the farthest candidate back to ptr so the nearest one wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr_i + IDX_W'(k);
      if (req_i[cand]) idx_o = cand;
    end
  end

endmodule

// File: rtl/mux4x1_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux: grants one requester at a time,
// caps each grant at MAX_HOLD cycles and inserts a one-cycle turnaround.
module mux4x1_rr_arbiter
  import mux4x1_ctrl_defs::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mux4x1_rr_arbiter_if.master  bus
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             owner_req;
  logic             hold_limit;

  rr_pick4 u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // sel_q always holds the current (or last) owner's index.
  assign owner_req  = bus.req[sel_q];
  assign hold_limit = (hold_q == CNT_W'(MAX_HOLD));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = onehot(pick_idx);
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          hold_d  = CNT_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req || hold_limit) begin
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = owner_req;
          ptr_d     = sel_q + IDX_W'(1);
          state_d   = TURN;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel1    = sel_q[1];
  assign bus.sel0    = sel_q[0];
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// Directed bench for mux4x1_rr_arbiter: a MAX_HOLD=8 instance for most
// scenarios and a MAX_HOLD=1 instance for the single-cycle-grant case.
module tb_mux4x1_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux4x1_rr_arbiter_if if8();
  mux4x1_rr_arbiter_if if1();

  mux4x1_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  mux4x1_rr_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  int checks   = 0;
  int failures = 0;

  // Observed/expected word: {gnt[3:0], sel1, sel0, busy, timeout}
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] obs8();
    return {if8.gnt, if8.sel1, if8.sel0, if8.busy, if8.timeout};
  endfunction

  function automatic logic [7:0] obs1();
    return {if1.gnt, if1.sel1, if1.sel0, if1.busy, if1.timeout};
  endfunction

  function automatic logic [7:0] ev(input logic [3:0] g, input logic [1:0] s,
                                    input logic b, input logic t);
    return {g, s, b, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] oh;
  int order [5] = '{0, 1, 2, 3, 0};
  logic [7:0] mh1_exp [7] = '{8'b0001_0010, 8'b0000_0001, 8'b0000_0000,
                              8'b0010_0110, 8'b0000_0101, 8'b0000_0100,
                              8'b0001_0010};

  initial begin
    if8.req = 4'b0000;
    if1.req = 4'b0000;

    // 1. reset and idle
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("reset_%0d", i), obs8(), 8'h00);
      check($sformatf("reset_mh1_%0d", i), obs1(), 8'h00);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("idle_%0d", i), obs8(), 8'h00);
    end

    // 2. single requester 2 for three cycles
    if8.req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("single_gnt_%0d", i), obs8(), ev(4'b0100, 2'd2, 1'b1, 1'b0));
    end
    if8.req = 4'b0000;
    tick();
    check("single_drop", obs8(), ev(4'b0000, 2'd2, 1'b0, 1'b0));

    // 4a. ptr=3, req=0101 -> requester 0 wins via wrap
    if8.req = 4'b0101;
    tick();
    check("wrap_idle", obs8(), ev(4'b0000, 2'd2, 1'b0, 1'b0));
    tick();
    check("wrap_gnt0", obs8(), ev(4'b0001, 2'd0, 1'b1, 1'b0));

    // 4b. requester 0 releases -> ptr=1, req=0101 -> requester 2 wins
    if8.req = 4'b0100;
    tick();
    check("rel0_turn", obs8(), ev(4'b0000, 2'd0, 1'b0, 1'b0));
    if8.req = 4'b0101;
    tick();
    check("rel0_idle", obs8(), ev(4'b0000, 2'd0, 1'b0, 1'b0));
    tick();
    check("ptr1_gnt2", obs8(), ev(4'b0100, 2'd2, 1'b1, 1'b0));

    // move ptr to 0 via a short grant to requester 3
    if8.req = 4'b0000;
    tick();
    check("rel2_turn", obs8(), ev(4'b0000, 2'd2, 1'b0, 1'b0));
    if8.req = 4'b1000;
    tick();
    tick();
    check("gnt3", obs8(), ev(4'b1000, 2'd3, 1'b1, 1'b0));
    if8.req = 4'b0000;
    tick();
    tick();
    check("rel3_idle", obs8(), ev(4'b0000, 2'd3, 1'b0, 1'b0));

    // 3. all requesting: 0,1,2,3,0 with 8-cycle grants and timeouts
    if8.req = 4'b1111;
    tick();
    for (int j = 0; j < 5; j++) begin
      oh = 4'b0001 << order[j];
      for (int k = 0; k < 8; k++) begin
        check($sformatf("rr_o%0d_k%0d", j, k), obs8(),
              ev(oh, 2'(order[j]), 1'b1, 1'b0));
        tick();
      end
      check($sformatf("rr_timeout_%0d", j), obs8(), ev(4'b0000, 2'(order[j]), 1'b0, 1'b1));
      tick();
      check($sformatf("rr_gap_%0d", j), obs8(), ev(4'b0000, 2'(order[j]), 1'b0, 1'b0));
      tick();
    end

    // 5. reset mid-grant: requester 1 at hold count 4
    if8.req = 4'b0010;
    check("mid_start", obs8(), ev(4'b0010, 2'd1, 1'b1, 1'b0));
    tick();
    tick();
    tick();
    check("mid_hold4", obs8(), ev(4'b0010, 2'd1, 1'b1, 1'b0));
    rst = 1'b1;
    tick();
    check("mid_rst", obs8(), 8'h00);
    rst = 1'b0;
    tick();
    check("post_rst_gnt", obs8(), ev(4'b0010, 2'd1, 1'b1, 1'b0));
    for (int k = 1; k < 8; k++) begin
      tick();
      check($sformatf("post_rst_hold_%0d", k), obs8(), ev(4'b0010, 2'd1, 1'b1, 1'b0));
    end
    tick();
    check("post_rst_timeout", obs8(), ev(4'b0000, 2'd1, 1'b0, 1'b1));
    tick();
    check("timeout_single", obs8(), ev(4'b0000, 2'd1, 1'b0, 1'b0));
    if8.req = 4'b0000;

    // 6. MAX_HOLD=1 instance with req=0011
    check("mh1_idle", obs1(), 8'h00);
    if1.req = 4'b0011;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("mh1_%0d", i), obs1(), mh1_exp[i]);
    end
    if1.req = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4x1_rr_arbiter.md
Name: mux4x1_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 mux output between four requesters. It samples a 4-bit request vector and grants exactly one requester at a time. It drives the mux select lines (sel1, sel0) to match the granted requester. A hold-time limit keeps any single requester from monopolising the shared output, and a one-cycle turnaround between owners keeps the mux output glitch-free at handover.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one requester may keep a grant (legal range 1..255).
CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
clk      input   1  single clock; all state updates on rising edge
rst      input   1  reset, synchronous, active-high
req      input   4  request vector; req[i] high = requester i wants the shared output
gnt      output  4  one-hot grant; all-zero when no owner
sel1     output  1  mux select MSB; encodes index of current/last owner
sel0     output  1  mux select LSB
busy     output  1  high while a grant is active (gnt != 0)
timeout  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - gnt=4'b0000, sel1=0, sel0=0, busy=0, timeout=0.
  - Priority pointer ptr=0; hold counter=0; state=IDLE.
- rst asserted mid-grant: all state returns to reset values at the next edge, regardless of req. No timeout pulse is generated.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req==0: stay in IDLE.
  - Otherwise select the first i with req[i]=1, searching ptr, ptr+1, ... mod 4.
  - At the same edge: gnt=onehot(i), {sel1,sel0}=i, busy=1, hold counter=1, go to GRANT.
  - Latency from req rising (sampled at edge N) to gnt visible after edge N: 1 cycle.
- GRANT (owner o):
  - If req[o]==0: gnt=0, busy=0, ptr=(o+1) mod 4, go to TURN.
  - Else if hold counter==MAX_HOLD: gnt=0, busy=0, timeout=1 for that one cycle, ptr=(o+1) mod 4, go to TURN.
  - Else: hold counter +1, stay in GRANT.
  - Net effect: the owner holds gnt for at most MAX_HOLD cycles.
- TURN:
  - Lasts exactly one cycle with gnt=0, then goes to IDLE.
  - Arbitration resumes in IDLE on the following edge.
  - Result: two cycles between one owner's gnt falling and the next owner's gnt rising.
- sel1/sel0 change only when a new grant is issued. They hold the last owner's index in TURN and IDLE, so the mux output never changes during a grant.
- Requests seen during GRANT or TURN do not affect the current grant; they are arbitrated in IDLE.
- Simultaneous requests are resolved by ptr order only; no requester can be starved.
- A timed-out owner keeping req high re-competes normally, with lowest priority after the pointer advance.
- MAX_HOLD=1: every grant lasts exactly one cycle and every release is a timeout pulse, unless req[o] dropped first.
- Invariants:
  - gnt is always one-hot or zero.
  - busy == |gnt.
  - timeout is never high in consecutive cycles.

Decomposition:
- Shared package/header `mux4x1_ctrl_defs`:
  - State encodings IDLE=2'd0, GRANT=2'd1, TURN=2'd2.
  - Requester count constant N_REQ=4.
- One sub-module is natural: `rr_pick4`. Combinational; inputs req[3:0] and ptr[1:0]; outputs the winner index[1:0] and a valid flag. It is reusable by other session blocks.
- The top holds the FSM, ptr, hold counter and output registers. The existing 4:1 mux is instantiated beside this block at system level, not inside it.

Test Plan:
1. Reset and idle: rst=1 for 2 cycles, then req=0000 for 5 cycles -> gnt=0000, sel1/sel0=0/0, busy=0, timeout=0 throughout.
2. Single requester: req=0100 at cycle 0, dropped after 3 cycles -> gnt=0100 and sel=10 one cycle after req; gnt=0000 one cycle after drop; sel stays 10 afterwards; ptr advances to 3.
3. Round robin: req=1111 held, MAX_HOLD=8 -> grant order 0,1,2,3,0. Each grant lasts 8 cycles with a timeout pulse at each revoke. Gap between grants is 2 cycles with gnt=0000.
4. Fairness after release: after requester 2 releases, req=0101 -> next grant goes to 0, not 2 (ptr=3 wraps to 0). If ptr=1 instead, the grant goes to 2.
5. Reset mid-grant: requester 1 granted at hold count 4, rst pulsed one cycle -> next edge gnt=0000, sel=00, busy=0, no timeout pulse. With req=0010 still high, gnt=0010 returns one cycle after rst drops.
6. MAX_HOLD=1 build: req=0011 held -> gnt alternates 0001, 0000, 0000, 0010, 0000, 0000, 0001…, with a timeout pulse on each revoke cycle.
